// File: rtl/vxe_regio_arb_if.sv
// Requester and regio-side signal bundle for vxe_regio_arb.
// The slave modport is the arbiter's view; master is the requesters/regio side.
interface vxe_regio_arb_if;
  logic        m0_req;
  logic        m0_wr;
  logic [9:0]  m0_idx;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rsp_vld;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_wr;
  logic [9:0]  m1_idx;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rsp_vld;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic [9:0]  wreg_idx;
  logic [31:0] wdata;
  logic        wenable;
  logic        waccept;
  logic        werror;
  logic [9:0]  rreg_idx;
  logic [31:0] rdata;
  logic        renable;
  logic        raccept;
  logic        rerror;

  modport slave (
    input  m0_req, m0_wr, m0_idx, m0_wdata,
    output m0_gnt, m0_rsp_vld, m0_rdata, m0_err,
    input  m1_req, m1_wr, m1_idx, m1_wdata,
    output m1_gnt, m1_rsp_vld, m1_rdata, m1_err,
    output wreg_idx, wdata, wenable,
    input  waccept, werror,
    output rreg_idx, renable,
    input  rdata, raccept, rerror
  );

  modport master (
    output m0_req, m0_wr, m0_idx, m0_wdata,
    input  m0_gnt, m0_rsp_vld, m0_rdata, m0_err,
    output m1_req, m1_wr, m1_idx, m1_wdata,
    input  m1_gnt, m1_rsp_vld, m1_rdata, m1_err,
    input  wreg_idx, wdata, wenable,
    output waccept, werror,
    input  rreg_idx, renable,
    output rdata, raccept, rerror
  );
endinterface

// File: rtl/vxe_regio_arb.sv
// Two-port round-robin arbiter/sequencer sharing the single VxEngine regio access port.
// Optional ISSUE-phase timeout is built when VXE_REGIO_ARB_TIMEOUT_EN is defined.
module vxe_regio_arb #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic            clk,
  input logic            nrst,
  vxe_regio_arb_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;   // 0: m0, 1: m1
  logic        last_q, last_d;     // requester served last, 1: m1
  logic        first_q, first_d;   // marks the first ISSUE cycle (grant pulse)
  logic        wr_q, wr_d;
  logic [9:0]  idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        m0_err_q, m0_err_d;
  logic        m1_err_q, m1_err_d;

  logic        any_req;
  logic        sel_m1;
  logic        accept;
  logic        timeout;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("vxe_regio_arb: TIMEOUT must be in 1..255");
  end

  assign any_req = bus.m0_req | bus.m1_req;
  // On a tie the requester not served last wins.
  assign sel_m1  = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
  assign accept  = wr_q ? bus.waccept : bus.raccept;

`ifdef VXE_REGIO_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (state_q == StIssue && !accept) begin
      cnt_d   = cnt_q + 8'd1;
      timeout = (cnt_q == 8'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    if (accept) begin
      rsp_rdata = wr_q ? 32'h0 : bus.rdata;
      rsp_err   = wr_q ? bus.werror : bus.rerror;
    end else begin
      rsp_rdata = 32'hdead_beef;
      rsp_err   = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    first_d    = 1'b0;
    wr_d       = wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_err_d   = m0_err_q;
    m1_err_d   = m1_err_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = sel_m1;
          wr_d    = sel_m1 ? bus.m1_wr    : bus.m0_wr;
          idx_d   = sel_m1 ? bus.m1_idx   : bus.m0_idx;
          wdata_d = sel_m1 ? bus.m1_wdata : bus.m0_wdata;
          first_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (accept || timeout) begin
          if (owner_q) begin
            m1_rdata_d = rsp_rdata;
            m1_err_d   = rsp_err;
          end else begin
            m0_rdata_d = rsp_rdata;
            m0_err_d   = rsp_err;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      first_q    <= 1'b0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      first_q    <= first_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
    end
  end

  assign bus.m0_gnt     = (state_q == StIssue) && first_q && !owner_q;
  assign bus.m1_gnt     = (state_q == StIssue) && first_q &&  owner_q;
  assign bus.m0_rsp_vld = (state_q == StResp) && !owner_q;
  assign bus.m1_rsp_vld = (state_q == StResp) &&  owner_q;
  assign bus.m0_rdata   = m0_rdata_q;
  assign bus.m1_rdata   = m1_rdata_q;
  assign bus.m0_err     = m0_err_q;
  assign bus.m1_err     = m1_err_q;

  assign bus.wenable    = (state_q == StIssue) &&  wr_q;
  assign bus.renable    = (state_q == StIssue) && !wr_q;
  assign bus.wreg_idx   = idx_q;
  assign bus.rreg_idx   = idx_q;
  assign bus.wdata      = wdata_q;

endmodule

// File: tb/tb_vxe_regio_arb.sv
// Self-checking bench for vxe_regio_arb: directed scenarios plus randomized batches
// checked against a transaction-level round-robin model.
module tb_vxe_regio_arb;
  localparam int unsigned TimeoutCyc = 3;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  vxe_regio_arb_if bus ();

  vxe_regio_arb #(.TIMEOUT(TimeoutCyc)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.m0_req = 1'b0; bus.m0_wr = 1'b0; bus.m0_idx = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_wr = 1'b0; bus.m1_idx = '0; bus.m1_wdata = '0;
    bus.waccept = 1'b0; bus.werror = 1'b0;
    bus.raccept = 1'b0; bus.rerror = 1'b0; bus.rdata = '0;
  endtask

  task automatic set_port(input int p, input logic req, input logic wr,
                          input logic [9:0] idx, input logic [31:0] wd);
    if (p == 0) begin
      bus.m0_req = req; bus.m0_wr = wr; bus.m0_idx = idx; bus.m0_wdata = wd;
    end else begin
      bus.m1_req = req; bus.m1_wr = wr; bus.m1_idx = idx; bus.m1_wdata = wd;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rsp_vld, bus.m1_rsp_vld, bus.wenable, bus.renable}
        !== 6'b0)
      $display("FAIL reset_ctrl: got %b%b%b%b%b%b want 000000", bus.m0_gnt, bus.m1_gnt,
               bus.m0_rsp_vld, bus.m1_rsp_vld, bus.wenable, bus.renable);
    else pass_cnt++;
    total_cnt++;
    if ({bus.m0_rdata, bus.m1_rdata, bus.m0_err, bus.m1_err} !== 66'b0)
      $display("FAIL reset_rsp: got %h %h %b %b want all 0", bus.m0_rdata, bus.m1_rdata,
               bus.m0_err, bus.m1_err);
    else pass_cnt++;
    total_cnt++;
    if ({bus.wreg_idx, bus.rreg_idx, bus.wdata} !== 52'b0)
      $display("FAIL reset_idx: got %h %h %h want all 0", bus.wreg_idx, bus.rreg_idx,
               bus.wdata);
    else pass_cnt++;
    nrst = 1'b1;
  endtask

  task automatic test_single_write();
    clear_inputs();
    set_port(0, 1'b1, 1'b1, 10'h008, 32'h1234_5678);
    bus.waccept = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.wenable, bus.renable} !== 4'b1010)
      $display("FAIL wr_issue_ctrl: got %b%b%b%b want 1010", bus.m0_gnt, bus.m1_gnt,
               bus.wenable, bus.renable);
    else pass_cnt++;
    total_cnt++;
    if (bus.wreg_idx !== 10'h008 || bus.wdata !== 32'h1234_5678)
      $display("FAIL wr_issue_data: got %h %h want 008 12345678", bus.wreg_idx, bus.wdata);
    else pass_cnt++;
    bus.m0_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.m0_rsp_vld, bus.m1_rsp_vld, bus.wenable, bus.m0_err} !== 4'b1000 ||
        bus.m0_rdata !== 32'h0)
      $display("FAIL wr_rsp: got vld %b/%b wen %b err %b rdata %h want 1/0 0 0 0",
               bus.m0_rsp_vld, bus.m1_rsp_vld, bus.wenable, bus.m0_err, bus.m0_rdata);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.m0_rsp_vld, bus.m0_gnt, bus.wenable} !== 3'b000)
      $display("FAIL wr_idle: got %b%b%b want 000", bus.m0_rsp_vld, bus.m0_gnt, bus.wenable);
    else pass_cnt++;
  endtask

  task automatic test_single_read();
    int ren = 0;
    int wen = 0;
    int rsp = 0;
    logic [31:0] got = '0;
    clear_inputs();
    set_port(1, 1'b1, 1'b0, 10'h000, 32'h0);
    bus.raccept = 1'b1;
    bus.rdata   = 32'hcafe_0001;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.m1_gnt === 1'b1) bus.m1_req = 1'b0;
      if (bus.renable === 1'b1) ren++;
      if (bus.wenable !== 1'b0) wen++;
      if (bus.m1_rsp_vld === 1'b1) begin
        rsp++;
        got = bus.m1_rdata;
      end
    end
    total_cnt++;
    if (ren != 1) $display("FAIL rd_renable_cycles: got %0d want 1", ren);
    else pass_cnt++;
    total_cnt++;
    if (wen != 0) $display("FAIL rd_wenable_cycles: got %0d want 0", wen);
    else pass_cnt++;
    total_cnt++;
    if (rsp != 1 || got !== 32'hcafe_0001)
      $display("FAIL rd_rsp: got %0d rsp rdata %h want 1 rsp cafe0001", rsp, got);
    else pass_cnt++;
    total_cnt++;
    if (bus.m0_rdata !== 32'h0 || bus.m0_err !== 1'b0)
      $display("FAIL rd_other_hold: got %h %b want 0 0", bus.m0_rdata, bus.m0_err);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    clear_inputs();
    nrst = 1'b0;
    set_port(0, 1'b1, 1'b1, 10'h101, 32'haaaa_0000);
    set_port(1, 1'b1, 1'b0, 10'h202, 32'h0);
    bus.waccept = 1'b1;
    bus.raccept = 1'b1;
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      // Cycle 0 of every 3 is a grant, owners alternate starting with m0.
      exp = (i % 3 != 0) ? 2'b00 : (((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
      total_cnt++;
      if ({bus.m1_gnt, bus.m0_gnt} !== exp)
        $display("FAIL rr_gnt_c%0d: got m1/m0 %b%b want %b", i, bus.m1_gnt, bus.m0_gnt, exp);
      else pass_cnt++;
      if (i == 11) begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
      end
    end
  endtask

  task automatic test_delayed_accept();
    clear_inputs();
    set_port(0, 1'b1, 1'b0, 10'h155, 32'h0);
    bus.rdata = 32'h0bad_f00d;
`ifdef VXE_REGIO_ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) bus.m0_req = 1'b0;
      total_cnt++;
      if (bus.renable !== 1'b1 || bus.rreg_idx !== 10'h155)
        $display("FAIL dly_hold_c%0d: got ren %b idx %h want 1 155", k, bus.renable,
                 bus.rreg_idx);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (bus.m0_rsp_vld !== 1'b1 || bus.m0_err !== 1'b1 || bus.m0_rdata !== 32'hdead_beef ||
        bus.renable !== 1'b0)
      $display("FAIL dly_timeout_rsp: got vld %b err %b rdata %h ren %b want 1 1 deadbeef 0",
               bus.m0_rsp_vld, bus.m0_err, bus.m0_rdata, bus.renable);
    else pass_cnt++;
`else
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) bus.m0_req = 1'b0;
      total_cnt++;
      if (bus.renable !== 1'b1 || bus.rreg_idx !== 10'h155 || bus.m0_rsp_vld !== 1'b0)
        $display("FAIL dly_hold_c%0d: got ren %b idx %h vld %b want 1 155 0", k, bus.renable,
                 bus.rreg_idx, bus.m0_rsp_vld);
      else pass_cnt++;
      if (k == 5) bus.raccept = 1'b1;
    end
    @(negedge clk);
    bus.raccept = 1'b0;
    total_cnt++;
    if (bus.m0_rsp_vld !== 1'b1 || bus.m0_err !== 1'b0 || bus.m0_rdata !== 32'h0bad_f00d ||
        bus.renable !== 1'b0)
      $display("FAIL dly_rsp: got vld %b err %b rdata %h ren %b want 1 0 0badf00d 0",
               bus.m0_rsp_vld, bus.m0_err, bus.m0_rdata, bus.renable);
    else pass_cnt++;
`endif
    @(negedge clk);
  endtask

  task automatic test_error();
    clear_inputs();
    set_port(0, 1'b1, 1'b1, 10'h033, 32'h5555_aaaa);
    bus.waccept = 1'b1;
    bus.werror  = 1'b1;
    @(negedge clk);
    bus.m0_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.m0_rsp_vld !== 1'b1 || bus.m0_err !== 1'b1 || bus.m0_rdata !== 32'h0)
      $display("FAIL err_rsp: got vld %b err %b rdata %h want 1 1 0", bus.m0_rsp_vld,
               bus.m0_err, bus.m0_rdata);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_in_issue();
    clear_inputs();
    set_port(0, 1'b1, 1'b1, 10'h3ff, 32'hffff_0000);
    @(negedge clk);
    total_cnt++;
    if (bus.m0_gnt !== 1'b1 || bus.wenable !== 1'b1)
      $display("FAIL rst_pre_issue: got gnt %b wen %b want 1 1", bus.m0_gnt, bus.wenable);
    else pass_cnt++;
    nrst = 1'b0;
    bus.m0_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rsp_vld, bus.m1_rsp_vld, bus.wenable, bus.renable}
        !== 6'b0 || {bus.m0_rdata, bus.m1_rdata, bus.m0_err, bus.m1_err} !== 66'b0 ||
        {bus.wreg_idx, bus.rreg_idx, bus.wdata} !== 52'b0)
      $display("FAIL rst_mid_clear: got ctrl %b%b%b%b%b%b err %b data %h idx %h want all 0",
               bus.m0_gnt, bus.m1_gnt, bus.m0_rsp_vld, bus.m1_rsp_vld, bus.wenable,
               bus.renable, bus.m0_err, bus.wdata, bus.wreg_idx);
    else pass_cnt++;
    nrst = 1'b1;
    set_port(0, 1'b1, 1'b1, 10'h011, 32'h0000_0011);
    set_port(1, 1'b1, 1'b0, 10'h022, 32'h0);
    bus.waccept = 1'b1;
    bus.raccept = 1'b1;
    bus.rdata   = 32'h0000_2222;
    @(negedge clk);
    total_cnt++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b01 || bus.m0_rsp_vld !== 1'b0)
      $display("FAIL rst_tie_first: got m1/m0 %b%b vld %b want 01 0", bus.m1_gnt, bus.m0_gnt,
               bus.m0_rsp_vld);
    else pass_cnt++;
    bus.m0_req = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({bus.m1_gnt, bus.m0_gnt} !== 2'b10)
      $display("FAIL rst_tie_second: got m1/m0 %b%b want 10", bus.m1_gnt, bus.m0_gnt);
    else pass_cnt++;
    bus.m1_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    bit          last_m1;
    logic [31:0] mdl_rdata[2];
    logic        mdl_err[2];
    logic        wr_a[2];
    logic [9:0]  idx_a[2];
    logic [31:0] wd_a[2];
    int          order[2];
    int          n, gi, got, cyc, cur, dly, acc_cnt, pat, p;
    logic [31:0] rd;
    logic        er, acc;
    clear_inputs();
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    last_m1 = 1'b1;
    mdl_rdata[0] = '0; mdl_rdata[1] = '0;
    mdl_err[0] = 1'b0; mdl_err[1] = 1'b0;
    cur = 0; dly = 0; acc_cnt = 0; rd = '0; er = 1'b0;
    for (int b = 0; b < 40; b++) begin
      pat = int'($urandom_range(1, 3));
      for (int q = 0; q < 2; q++) begin
        wr_a[q]  = 1'($urandom);
        idx_a[q] = 10'($urandom);
        wd_a[q]  = $urandom;
      end
      if (pat == 3) begin
        order[0] = last_m1 ? 0 : 1;
        order[1] = 1 - order[0];
        n = 2;
      end else begin
        order[0] = (pat == 2) ? 1 : 0;
        order[1] = order[0];
        n = 1;
      end
      set_port(0, pat[0], wr_a[0], idx_a[0], wd_a[0]);
      set_port(1, pat[1], wr_a[1], idx_a[1], wd_a[1]);
      gi = 0; got = 0; cyc = 0;
      while (got < n && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (bus.m0_gnt === 1'b1 || bus.m1_gnt === 1'b1) begin
          total_cnt++;
          if (gi >= n || {bus.m1_gnt, bus.m0_gnt} !== ((order[gi] == 1) ? 2'b10 : 2'b01))
            $display("FAIL rnd_gnt_b%0d: got m1/m0 %b%b want port %0d", b, bus.m1_gnt,
                     bus.m0_gnt, (gi < n) ? order[gi] : -1);
          else pass_cnt++;
          gi++;
          cur = (bus.m1_gnt === 1'b1) ? 1 : 0;
          if (cur == 1) bus.m1_req = 1'b0;
          else bus.m0_req = 1'b0;
          dly = int'($urandom_range(0, 2));
          rd  = $urandom;
          er  = 1'($urandom);
          acc_cnt = 0;
        end
        if (bus.wenable === 1'b1 || bus.renable === 1'b1) begin
          total_cnt++;
          if ({bus.wenable, bus.renable} !== (wr_a[cur] ? 2'b10 : 2'b01) ||
              (wr_a[cur] && (bus.wreg_idx !== idx_a[cur] || bus.wdata !== wd_a[cur])) ||
              (!wr_a[cur] && bus.rreg_idx !== idx_a[cur]))
            $display("FAIL rnd_issue_b%0d: got wen %b ren %b widx %h wd %h ridx %h want wr %b idx %h wd %h",
                     b, bus.wenable, bus.renable, bus.wreg_idx, bus.wdata, bus.rreg_idx,
                     wr_a[cur], idx_a[cur], wd_a[cur]);
          else pass_cnt++;
          acc = (acc_cnt == dly);
          acc_cnt++;
          bus.rdata = rd;
          if (wr_a[cur]) begin
            bus.waccept = acc; bus.werror = er;
            bus.raccept = 1'($urandom); bus.rerror = ~er;
          end else begin
            bus.raccept = acc; bus.rerror = er;
            bus.waccept = 1'($urandom); bus.werror = ~er;
          end
        end else begin
          bus.waccept = 1'b0;
          bus.raccept = 1'b0;
        end
        if (bus.m0_rsp_vld === 1'b1 || bus.m1_rsp_vld === 1'b1) begin
          p = order[got];
          mdl_rdata[p] = wr_a[p] ? 32'h0 : rd;
          mdl_err[p]   = er;
          total_cnt++;
          if ({bus.m1_rsp_vld, bus.m0_rsp_vld} !== ((p == 1) ? 2'b10 : 2'b01) ||
              bus.m0_rdata !== mdl_rdata[0] || bus.m0_err !== mdl_err[0] ||
              bus.m1_rdata !== mdl_rdata[1] || bus.m1_err !== mdl_err[1])
            $display("FAIL rnd_rsp_b%0d: got vld %b%b m0 %h/%b m1 %h/%b want port %0d m0 %h/%b m1 %h/%b",
                     b, bus.m1_rsp_vld, bus.m0_rsp_vld, bus.m0_rdata, bus.m0_err,
                     bus.m1_rdata, bus.m1_err, p, mdl_rdata[0], mdl_err[0], mdl_rdata[1],
                     mdl_err[1]);
          else pass_cnt++;
          last_m1 = (p == 1);
          got++;
        end
      end
      if (got < n) begin
        total_cnt++;
        $display("FAIL rnd_timeout_b%0d: got %0d responses want %0d", b, got, n);
      end
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_delayed_accept();
    test_error();
    test_reset_in_issue();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
